// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command sequencer wrapped around the 8-bit combinational ALU. Accepts one
// operation per cmd handshake, registers the ALU operands/opcode, captures the
// ALU result one cycle later and returns it on a valid/ready response port.
// Illegal opcodes (1110/1111) and divide-by-zero are answered directly without
// sampling the ALU. Keeps an accumulator (optionally used as operand A) and a
// count of completed responses.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/cmd_a/cmd_b       opcode and operands
//   cmd_use_acc              take operand A from the accumulator
//   alu_operand_a/b, alu_op_code   registered ALU inputs
//   alu_result, alu_carry_out      ALU outputs
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_carry, rsp_div_zero, rsp_illegal   response payload
//   acc                      accumulator
//   op_count                 completed responses, wraps modulo 256
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [7:0] alu_operand_a,
  output logic [7:0] alu_operand_b,
  output logic [3:0] alu_op_code,
  input  logic [7:0] alu_result,
  input  logic       alu_carry_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_div_zero,
  output logic       rsp_illegal,
  output logic [7:0] acc,
  output logic [7:0] op_count
);

  localparam int unsigned DataW = 8;
  localparam int unsigned OpW   = 4;

  localparam logic [OpW-1:0] OpAdd = OpW'(4'b0000);
  localparam logic [OpW-1:0] OpSub = OpW'(4'b0001);
  localparam logic [OpW-1:0] OpDiv = OpW'(4'b0011);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_RESPOND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0] opa_q, opa_d;
  logic [DataW-1:0] opb_q, opb_d;
  logic [OpW-1:0]   op_q, op_d;
  logic [DataW-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             div_zero_q, div_zero_d;
  logic             illegal_q, illegal_d;
  logic [DataW-1:0] acc_q, acc_d;
  logic [DataW-1:0] count_q, count_d;

  logic cmd_fire;
  logic cmd_is_illegal;
  logic cmd_is_div_zero;

  assign cmd_fire        = cmd_valid && cmd_ready_q;
  assign cmd_is_illegal  = (cmd_op[3:1] == 3'b111);
  assign cmd_is_div_zero = (cmd_op == OpDiv) && (cmd_b == DataW'(0));

  // Next-state and next-output logic; ready/valid depend only on the state.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_d        = op_q;
    result_d    = result_q;
    carry_d     = carry_q;
    div_zero_d  = div_zero_q;
    illegal_d   = illegal_q;
    acc_d       = acc_q;
    count_d     = count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d        = cmd_op;
          opa_d       = cmd_use_acc ? acc_q : cmd_a;
          opb_d       = cmd_b;
          cmd_ready_d = 1'b0;
          if (cmd_is_illegal) begin
            result_d    = DataW'(0);
            carry_d     = 1'b0;
            illegal_d   = 1'b1;
            div_zero_d  = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESPOND;
          end else if (cmd_is_div_zero) begin
            result_d    = DataW'(8'hFF);
            carry_d     = 1'b0;
            illegal_d   = 1'b0;
            div_zero_d  = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_RESPOND;
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        // Carry is only meaningful for ADD/SUB; masked for everything else.
        result_d    = alu_result;
        carry_d     = ((op_q == OpAdd) || (op_q == OpSub)) ? alu_carry_out : 1'b0;
        div_zero_d  = 1'b0;
        illegal_d   = 1'b0;
        acc_d       = alu_result;
        rsp_valid_d = 1'b1;
        state_d     = S_RESPOND;
      end

      S_RESPOND: begin
        if (rsp_ready) begin
          count_d     = count_q + DataW'(1);
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      opa_q       <= DataW'(0);
      opb_q       <= DataW'(0);
      op_q        <= OpW'(0);
      result_q    <= DataW'(0);
      carry_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
      acc_q       <= DataW'(0);
      count_q     <= DataW'(0);
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      div_zero_q  <= div_zero_d;
      illegal_q   <= illegal_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign alu_operand_a = opa_q;
  assign alu_operand_b = opb_q;
  assign alu_op_code   = op_q;
  assign rsp_result    = result_q;
  assign rsp_carry     = carry_q;
  assign rsp_div_zero  = div_zero_q;
  assign rsp_illegal   = illegal_q;
  assign acc           = acc_q;
  assign op_count      = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed vector table plus hand-written
// sequences for reset, accumulator chaining, rejection, backpressure and wrap.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic [7:0] alu_operand_a;
  logic [7:0] alu_operand_b;
  logic [3:0] alu_op_code;
  logic [7:0] alu_result;
  logic       alu_carry_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_div_zero;
  logic       rsp_illegal;
  logic [7:0] acc;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_acc;
  logic [7:0] exp_cnt;

  alu_op_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_use_acc   (cmd_use_acc),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_op_code   (alu_op_code),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
    .rsp_div_zero  (rsp_div_zero),
    .rsp_illegal   (rsp_illegal),
    .acc           (acc),
    .op_count      (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU. Non-ADD/SUB ops deliberately raise carry in places so the
  // sequencer's carry masking is exercised.
  always_comb begin
    alu_result    = 8'h00;
    alu_carry_out = 1'b0;
    case (alu_op_code)
      4'h0: {alu_carry_out, alu_result} = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
      4'h1: begin
        alu_result    = alu_operand_a - alu_operand_b;
        alu_carry_out = (alu_operand_a < alu_operand_b);
      end
      4'h2: begin
        alu_result    = 8'(16'(alu_operand_a) * 16'(alu_operand_b));
        alu_carry_out = ((16'(alu_operand_a) * 16'(alu_operand_b)) > 16'h00FF);
      end
      4'h3: alu_result = (alu_operand_b == 8'h00) ? 8'hFF : alu_operand_a / alu_operand_b;
      4'h6: alu_result = alu_operand_a ^ alu_operand_b;
      4'h8: begin
        alu_result    = alu_operand_a + 8'h01;
        alu_carry_out = (alu_operand_a == 8'hFF);
      end
      default: begin
        alu_result    = alu_operand_a ^ 8'h3C;
        alu_carry_out = 1'b1;
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one command and return #1 after its accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ua);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = ua;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
  endtask

  // Cycles after the accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 8'h01;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_data"}, {alu_operand_a, alu_operand_b, alu_op_code, rsp_result, 4'h0},
        32'h0);
    chk({tag, "_flags"}, {29'h0, rsp_carry, rsp_div_zero, rsp_illegal}, 32'h0);
    chk({tag, "_acc_cnt"}, {16'h0, acc, op_count}, 32'h0);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       carry;
    logic       dz;
    logic       il;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;

    vecs[0]  = '{4'h0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'h0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'h1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'h1, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'h2, 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'h3, 8'h40, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 0};
    vecs[6]  = '{4'h3, 8'h40, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'hF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[8]  = '{4'hE, 8'h56, 8'h78, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[9]  = '{4'h6, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{4'h8, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{4'hD, 8'h11, 8'h22, 8'h2D, 1'b0, 1'b0, 1'b0, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    exp_acc = 8'h00; exp_cnt = 8'h00;
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    // Directed vector table.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      chk($sformatf("v%0d_ready_low", i), 32'(cmd_ready), 32'd0);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].result));
      chk($sformatf("v%0d_flags", i), {29'h0, rsp_carry, rsp_div_zero, rsp_illegal},
          {29'h0, vecs[i].carry, vecs[i].dz, vecs[i].il});
      if (!vecs[i].dz && !vecs[i].il) exp_acc = vecs[i].result;
      take_rsp();
      chk($sformatf("v%0d_acc", i), 32'(acc), 32'(exp_acc));
      chk($sformatf("v%0d_count", i), 32'(op_count), 32'(exp_cnt));
      chk($sformatf("v%0d_alu_hold", i), {alu_op_code, alu_operand_b},
          {vecs[i].op, vecs[i].b});
    end

    // SUB then MUL taking operand A from the accumulator.
    issue(4'h1, 8'h05, 8'h07, 1'b0);
    wait_rsp(lat);
    chk("chain_sub_result", 32'(rsp_result), 32'hFE);
    take_rsp();
    issue(4'h2, 8'h77, 8'h02, 1'b1);
    chk("chain_mul_opa", 32'(alu_operand_a), 32'hFE);
    wait_rsp(lat);
    chk("chain_mul_result", 32'(rsp_result), 32'hFC);
    chk("chain_mul_carry", 32'(rsp_carry), 32'd0);
    take_rsp();
    exp_acc = 8'hFC;
    chk("chain_acc", 32'(acc), 32'hFC);

    // Divide-by-zero then illegal: both rejected, acc untouched.
    issue(4'h3, 8'h40, 8'h00, 1'b0);
    chk("dz_immediate_valid", 32'(rsp_valid), 32'd1);
    chk("dz_payload", {rsp_result, 5'h0, rsp_carry, rsp_div_zero, rsp_illegal},
        {8'hFF, 8'h02});
    take_rsp();
    issue(4'hF, 8'h40, 8'h01, 1'b0);
    chk("il_immediate_valid", 32'(rsp_valid), 32'd1);
    chk("il_payload", {rsp_result, 5'h0, rsp_carry, rsp_div_zero, rsp_illegal},
        {8'h00, 8'h01});
    take_rsp();
    chk("reject_acc", 32'(acc), 32'(exp_acc));

    // Backpressure: response frozen for 10 cycles, single count on release.
    issue(4'h6, 8'hAA, 8'hFF, 1'b0);
    wait_rsp(lat);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp%0d_hold", k), {rsp_valid, cmd_ready, rsp_result, op_count},
          {1'b1, 1'b0, 8'h55, exp_cnt});
      @(posedge clk); #1;
    end
    take_rsp();
    chk("bp_count", 32'(op_count), 32'(exp_cnt));
    chk("bp_released", {rsp_valid, cmd_ready}, 2'b01);

    // Reset while in EXEC aborts the operation.
    issue(4'h0, 8'h01, 8'h01, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("rst_exec");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_exec_novalid%0d", k), 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    exp_acc = 8'h00; exp_cnt = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_exec_idle%0d", k), {rsp_valid, cmd_ready}, 2'b01);
    end

    // 256 accumulator INCs from zero: acc and op_count both wrap.
    for (int k = 0; k < 256; k++) begin
      issue(4'h8, 8'h99, 8'h00, 1'b1);
      wait_rsp(lat);
      chk($sformatf("inc%0d_result", k), {rsp_result, 7'h0, rsp_carry},
          {8'(k + 1), 8'h00});
      take_rsp();
    end
    chk("inc_acc_wrap", 32'(acc), 32'h00);
    chk("inc_count_wrap", 32'(op_count), 32'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if something wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
